ex_stage: RTL
=============

# ex_stage

Execute stage of the single-clock MIPS datapath. Sits between decode/register-read and the memory-access stage. Computes the 32-bit ALU result consumed downstream as the memory address, store-address or write-back data. Contains an iterative multiply/divide unit with HI/LO registers and raises a stall when an instruction needs that unit while it is busy.

## Interface

- No parameters.

- `CLK` in 1: clock, rising-edge active.
- `RST` in 1: reset, asynchronous, active-high.
- `Ins` in 32: current instruction. Op = `Ins[31:26]`, shamt = `Ins[10:6]`, funct = `Ins[5:0]`.
- `Rdata1` in 32: rs register value.
- `Rdata2` in 32: rt register value.
- `Ed32` in 32: sign-extended `Ins[15:0]`.
- `nextPC` in 32: PC+4 of the current instruction, used as the link value.
- `Result` out 32: combinational ALU result for the memory-access stage.
- `Stall` out 1: high means fetch must hold PC and `Ins`, and the register file must not write this cycle.

## Operation

- **R-type (Op=0), selected by funct:**
  - ADD 32 / ADDU 33: rs+rt.
  - SUB 34 / SUBU 35: rs−rt.
  - AND 36, OR 37, XOR 38, NOR 39.
  - SLT 42: signed compare. SLTU 43: unsigned compare. Both return 1 or 0.
  - SLL 0, SRL 2, SRA 3: shift rt by shamt.
  - JALR 9: result is `nextPC`.
  - MFHI 16: result is HI. MFLO 18: result is LO.
  - MTHI 17: rs is written to HI. MTLO 19: rs is written to LO.
  - MULT 24, MULTU 25, DIV 26, DIVU 27: start the mul/div unit.
- **I-type:**
  - ADDI 8 / ADDIU 9: rs+Ed32.
  - SLTI 10: signed compare with Ed32. SLTIU 11: unsigned compare with Ed32.
  - ANDI 12, ORI 13, XORI 14: zero-extended immediate.
  - LUI 15: `{Ins[15:0],16'h0}`.
  - LW 35 / SW 43: rs+Ed32.
- **J-type:** JAL 3 gives `nextPC`.
- **All other cases give Result = 0:**
  - any undefined opcode or funct;
  - MT*, MULT*, DIV*;
  - any cycle with `Stall`=1.
- All arithmetic wraps mod 2^32. There are no overflow traps.
- **Mul/div FSM states:** IDLE, RUN, FIX.
  - IDLE → RUN: on the issue edge of MULT*/DIV* with Stall=0. The edge latches operands as magnitudes (signed ops) or raw values (unsigned ops), plus the sign flags. Count is cleared to 0.
  - RUN: one iteration per edge. Multiply is shift-add into a 64-bit product. Divide is restoring, giving a 32-bit quotient and remainder. After the 32nd iteration, go to FIX.
  - FIX → IDLE: apply signs and write HI/LO.
- **Sign rules:**
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- **Results:** MULT* writes HI = product[63:32] and LO = product[31:0]. DIV* writes LO = quotient and HI = remainder.
- **Divide by zero:** LO = 32'hFFFFFFFF, HI = dividend (as supplied, sign intact). No trap.
- **Stall:** `Stall = (state != IDLE) && Ins ∈ {MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU}`. It is combinational.
  - Non-HI/LO instructions never stall and execute normally during RUN/FIX.
  - An instruction that stalls has no side effect. It does not start the unit and does not write HI/LO.

## Timing

- `Result` is combinational from `Ins`, `Rdata1`, `Rdata2`, `Ed32`, `nextPC`, HI and LO. Zero latency.
- MTHI/MTLO write HI/LO on the edge ending their cycle when Stall=0. The value is visible to MFHI/MFLO in the next cycle.
- **Mul/div latency, with issue in cycle N:**
  - RUN during cycles N+1..N+32.
  - FIX during cycle N+33.
  - HI/LO valid from cycle N+34.
  - An MFLO presented in cycle N+1 therefore sees `Stall` high for 33 cycles and completes in cycle N+34.
- HI/LO hold their old values until the FIX edge, never partial results.
- **Reset, asynchronous at any time including mid-RUN:**
  - state = IDLE, count = 0, HI = LO = 0.
  - Working registers are cleared; the aborted operation is discarded.
  - `Stall` = 0. `Result` = 0 for `Ins` = 0.
  - After reset release, the first edge may issue a new operation.

## Test plan

- ALU path:
  - ADD with Rdata1 = 5, Rdata2 = 0xFFFFFFFF → Result = 4.
  - SLT with −1 vs 1 → 1. SLTU with the same operands → 0.
  - SRA of rt = 0x80000000 by shamt 4 → 0xF8000000.
  - LUI with imm 0x1234 → 0x12340000.
  - JAL with nextPC = 0x44 → 0x44.
- Address path: LW and SW with Rdata1 = 0x1C, Ed32 = 4 → Result = 0x20 (matches the memory-access stage store/load address).
- MULT with rs = −3, rt = 7, followed immediately by MFLO then MFHI:
  - Stall high for exactly 33 cycles on MFLO.
  - MFLO then gives 0xFFFFFFEB; MFHI gives 0xFFFFFFFF, no stall.
  - An ADD placed between the MULT and the MFLO completes without stall.
- Division:
  - DIVU 100/7 → LO = 14, HI = 2.
  - DIV −7/2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 5/0 → LO = 0xFFFFFFFF, HI = 5.
- MTHI 0xA5A5A5A5, then MFHI next cycle → 0xA5A5A5A5. A second MULT issued while RUN is stalled until FIX completes, then runs its full 34-cycle latency.
- Reset mid-operation:
  - Assert RST at cycle N+10 of a MULT with rs = rt = 0xFFFF.
  - Stall drops immediately and HI = LO = 0.
  - A subsequent MFLO returns 0 without stall.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the single-clock MIPS datapath.
// Produces the combinational ALU result for the memory-access stage and
// hosts an iterative multiply/divide unit with its HI/LO registers.
// Any HI/LO instruction presented while that unit is busy raises Stall.

module ex_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  input  logic [31:0] nextPC,
  output logic [31:0] Result,
  output logic        Stall
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type function codes
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SRA   = 6'd3;
  localparam logic [5:0] FN_JALR  = 6'd9;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdState_e;

  mdState_e state_q, state_d;

  // Mul/div working registers.
  // Multiply: work holds {partial product high, remaining multiplier bits}.
  // Divide:   work holds {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] work_q, work_d;
  logic [31:0] opB_q, opB_d;
  logic [4:0]  count_q, count_d;
  logic        isDiv_q, isDiv_d;
  logic        negRes_q, negRes_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Instruction fields
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic [15:0] imm;
  logic        unusedInsBits;

  assign op    = Ins[31:26];
  assign funct = Ins[5:0];
  assign shamt = Ins[10:6];
  assign imm   = Ins[15:0];
  assign unusedInsBits = ^Ins[25:16];

  // Decode of the instructions that touch the mul/div unit or HI/LO
  logic isRType;
  logic isHiLoIns;
  logic isMulDivIns;
  logic issueMulDiv;
  logic writeHi;
  logic writeLo;

  assign isRType     = (op == OP_RTYPE);
  assign isMulDivIns = isRType && (funct == FN_MULT || funct == FN_MULTU ||
                                   funct == FN_DIV  || funct == FN_DIVU);
  assign isHiLoIns   = isMulDivIns ||
                       (isRType && (funct == FN_MFHI || funct == FN_MFLO ||
                                    funct == FN_MTHI || funct == FN_MTLO));
  assign issueMulDiv = isMulDivIns && !Stall;
  assign writeHi     = isRType && (funct == FN_MTHI) && !Stall;
  assign writeLo     = isRType && (funct == FN_MTLO) && !Stall;

  // Operand conditioning at issue: even funct codes are the signed variants,
  // bit 1 of funct separates divide from multiply.
  logic        issueSigned;
  logic        issueIsDiv;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] magA;
  logic [31:0] magB;

  assign issueSigned = ~funct[0];
  assign issueIsDiv  = funct[1];
  assign aNeg        = issueSigned & Rdata1[31];
  assign bNeg        = issueSigned & Rdata2[31];
  assign magA        = aNeg ? (32'd0 - Rdata1) : Rdata1;
  assign magB        = bNeg ? (32'd0 - Rdata2) : Rdata2;

  // One shift-add multiply iteration: add the multiplicand into the high
  // half when the current multiplier bit is set, then shift right with carry.
  logic [32:0] mulSum;
  logic [63:0] mulNext;

  assign mulSum  = work_q[0] ? ({1'b0, work_q[63:32]} + {1'b0, opB_q})
                             : {1'b0, work_q[63:32]};
  assign mulNext = {mulSum, work_q[31:1]};

  // One restoring-divide iteration: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits.
  logic [32:0] divShifted;
  logic [32:0] divDiff;
  logic        quotBit;
  logic [31:0] divRem;
  logic [63:0] divNext;

  assign divShifted = {work_q[63:32], work_q[31]};
  assign divDiff    = divShifted - {1'b0, opB_q};
  assign quotBit    = (divShifted >= {1'b0, opB_q});
  assign divRem     = quotBit ? divDiff[31:0] : divShifted[31:0];
  assign divNext    = {divRem, work_q[30:0], quotBit};

  // Final sign correction applied in FIX
  logic [63:0] mulFinal;
  logic [31:0] quotFinal;
  logic [31:0] remFinal;

  assign mulFinal  = negRes_q ? (64'd0 - work_q) : work_q;
  assign quotFinal = negRes_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
  assign remFinal  = negRem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];

  // Mul/div FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Mul/div FSM next-state logic: 32 RUN edges, then one FIX edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issueMulDiv) state_d = RUN;
      RUN:     if (count_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Mul/div FSM output logic: hold the pipeline for HI/LO users while busy
  always_comb begin
    Stall = (state_q != IDLE) && isHiLoIns;
  end

  // Datapath next-state: latch operands, iterate, then commit HI/LO
  always_comb begin
    work_d     = work_q;
    opB_d      = opB_q;
    count_d    = count_q;
    isDiv_d    = isDiv_q;
    negRes_d   = negRes_q;
    negRem_d   = negRem_q;
    divZero_d  = divZero_q;
    dividend_d = dividend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (issueMulDiv) begin
          work_d     = {32'd0, magA};
          opB_d      = magB;
          count_d    = 5'd0;
          isDiv_d    = issueIsDiv;
          negRes_d   = aNeg ^ bNeg;
          negRem_d   = aNeg;
          divZero_d  = (Rdata2 == 32'd0);
          dividend_d = Rdata1;
        end
        if (writeHi) hi_d = Rdata1;
        if (writeLo) lo_d = Rdata1;
      end
      RUN: begin
        work_d  = isDiv_q ? divNext : mulNext;
        count_d = count_q + 5'd1;
      end
      FIX: begin
        if (!isDiv_q) begin
          hi_d = mulFinal[63:32];
          lo_d = mulFinal[31:0];
        end else if (divZero_q) begin
          hi_d = dividend_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = remFinal;
          lo_d = quotFinal;
        end
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

  // Datapath registers; reset discards any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      work_q     <= 64'd0;
      opB_q      <= 32'd0;
      count_q    <= 5'd0;
      isDiv_q    <= 1'b0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      divZero_q  <= 1'b0;
      dividend_q <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      work_q     <= work_d;
      opB_q      <= opB_d;
      count_q    <= count_d;
      isDiv_q    <= isDiv_d;
      negRes_q   <= negRes_d;
      negRem_q   <= negRem_d;
      divZero_q  <= divZero_d;
      dividend_q <= dividend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // ALU result: zero for stalled, side-effect-only and undefined encodings
  always_comb begin
    Result = 32'd0;
    if (!Stall) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADD, FN_ADDU: Result = Rdata1 + Rdata2;
            FN_SUB, FN_SUBU: Result = Rdata1 - Rdata2;
            FN_AND:          Result = Rdata1 & Rdata2;
            FN_OR:           Result = Rdata1 | Rdata2;
            FN_XOR:          Result = Rdata1 ^ Rdata2;
            FN_NOR:          Result = ~(Rdata1 | Rdata2);
            FN_SLT:          Result = {31'd0, ($signed(Rdata1) < $signed(Rdata2))};
            FN_SLTU:         Result = {31'd0, (Rdata1 < Rdata2)};
            FN_SLL:          Result = Rdata2 << shamt;
            FN_SRL:          Result = Rdata2 >> shamt;
            FN_SRA:          Result = $unsigned($signed(Rdata2) >>> shamt);
            FN_JALR:         Result = nextPC;
            FN_MFHI:         Result = hi_q;
            FN_MFLO:         Result = lo_q;
            default:         Result = 32'd0;
          endcase
        end
        OP_ADDI, OP_ADDIU: Result = Rdata1 + Ed32;
        OP_SLTI:           Result = {31'd0, ($signed(Rdata1) < $signed(Ed32))};
        OP_SLTIU:          Result = {31'd0, (Rdata1 < Ed32)};
        OP_ANDI:           Result = Rdata1 & {16'd0, imm};
        OP_ORI:            Result = Rdata1 | {16'd0, imm};
        OP_XORI:           Result = Rdata1 ^ {16'd0, imm};
        OP_LUI:            Result = {imm, 16'd0};
        OP_LW, OP_SW:      Result = Rdata1 + Ed32;
        OP_JAL:            Result = nextPC;
        default:           Result = 32'd0;
      endcase
    end
  end

endmodule
